aib_follower_link_seq: RTL and testbench

// - Link bring-up sequencer for the AIB->AXI follower bridge. Runs the PHY's AVMM configuration

---
 rtl/aib_axi_bridge_pkg.sv | 10 +
 rtl/aib_follower_link_seq_if.sv | 21 ++
 rtl/aib_sync2.sv | 18 +
 rtl/aib_follower_link_seq.sv | 152 +++++++++++++++
 tb/tb_aib_follower_link_seq.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aib_axi_bridge_pkg.sv
// aib_axi_bridge_pkg: shared types and constants for the AIB->AXI follower bridge
package aib_axi_bridge_pkg;

    typedef enum logic [3:0] {
        IDLE, CFG, RST_HOLD, MAC_RDY, WAIT_XFER, WAIT_ALIGN, ONLINE, RETRY, FAULT
    } link_seq_state_t;

    localparam logic [3:0] AVMM_BYTE_EN_ALL = 4'hF;

endpackage

// File: rtl/aib_follower_link_seq_if.sv
// aib_follower_link_seq_if: PHY AVMM configuration bus driven by the link sequencer
interface aib_follower_link_seq_if;

    logic [16:0] cfg_avmm_addr;
    logic [31:0] cfg_avmm_wdata;
    logic        cfg_avmm_write;
    logic        cfg_avmm_read;
    logic [3:0]  cfg_avmm_byte_en;
    logic        cfg_avmm_waitreq;

    modport master (
        output cfg_avmm_addr, cfg_avmm_wdata, cfg_avmm_write, cfg_avmm_read, cfg_avmm_byte_en,
        input  cfg_avmm_waitreq
    );

    modport slave (
        input  cfg_avmm_addr, cfg_avmm_wdata, cfg_avmm_write, cfg_avmm_read, cfg_avmm_byte_en,
        output cfg_avmm_waitreq
    );

endinterface

// File: rtl/aib_sync2.sv
// aib_sync2: two-flop synchronizer with async reset to 0
module aib_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {q_o, meta_q} <= '0;
        else        {q_o, meta_q} <= {meta_q, d_i};
    end

endmodule

// File: rtl/aib_follower_link_seq.sv
// aib_follower_link_seq: AIB link bring-up sequencer (AVMM config, adapter reset, link monitor)
module aib_follower_link_seq
    import aib_axi_bridge_pkg::*;
#(
    parameter int  NBR_CHNLS    = 24,
    parameter int  ACTIVE_CHNLS = 1,
    parameter int  CFG_DEPTH    = 16,
    parameter int  RST_HOLD     = 64,
    parameter int  TIMEOUT_CYC  = 65536,
    parameter int  MAX_RETRY    = 3,
    localparam int CW           = $clog2(CFG_DEPTH),
    localparam int RW           = $clog2(MAX_RETRY + 1)
) (
    input  logic                    avmm_clk,
    input  logic                    avmm_rst_n,
    input  logic                    start,
    input  logic [CW:0]             cfg_count,
    output logic [CW-1:0]           cfg_idx,
    input  logic [16:0]             cfg_addr,
    input  logic [31:0]             cfg_wdata,
    aib_follower_link_seq_if.master avmm,
    output logic [NBR_CHNLS-1:0]    ns_adapter_rstn,
    output logic [NBR_CHNLS-1:0]    ns_mac_rdy,
    input  logic [NBR_CHNLS-1:0]    ms_tx_transfer_en,
    input  logic [NBR_CHNLS-1:0]    sl_tx_transfer_en,
    input  logic [NBR_CHNLS-1:0]    m_rx_align_done,
    output logic                    link_online,
    output logic                    link_fault,
    output logic [RW-1:0]           retry_cnt,
    output logic [3:0]              state
);

    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [NBR_CHNLS-1:0] ACT_MASK = {NBR_CHNLS{1'b1}} >> (NBR_CHNLS - ACTIVE_CHNLS);

    link_seq_state_t      state_q, state_d;
    logic [CW-1:0]        idx_q, idx_d;
    logic [16:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [16:0]          timer_q, timer_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [NBR_CHNLS-1:0] rstn_q, rstn_d, mac_q, mac_d;
    logic                 online_q, online_d, fault_q, fault_d;
    logic [NBR_CHNLS-1:0] ms_s, sl_s, al_s;
    logic                 xfer_ok, align_ok, accept, last, tmo, sat, unused_hi;

    aib_sync2 #(.W(NBR_CHNLS)) u_sync_ms (.clk(avmm_clk), .rst_n(avmm_rst_n), .d_i(ms_tx_transfer_en), .q_o(ms_s));
    aib_sync2 #(.W(NBR_CHNLS)) u_sync_sl (.clk(avmm_clk), .rst_n(avmm_rst_n), .d_i(sl_tx_transfer_en), .q_o(sl_s));
    aib_sync2 #(.W(NBR_CHNLS)) u_sync_al (.clk(avmm_clk), .rst_n(avmm_rst_n), .d_i(m_rx_align_done), .q_o(al_s));

    // channels above ACTIVE_CHNLS are synchronized but never looked at
    assign unused_hi = ^{ms_s, sl_s, al_s};
    assign xfer_ok   = &(ms_s[ACTIVE_CHNLS-1:0] & sl_s[ACTIVE_CHNLS-1:0]);
    assign align_ok  = &al_s[ACTIVE_CHNLS-1:0];
    assign accept    = write_q && !avmm.cfg_avmm_waitreq;
    assign last      = {1'b0, idx_q} == cfg_count - (CW+1)'(1);
    assign tmo       = timer_q == 17'(TIMEOUT_CYC - 1);
    assign sat       = retry_q == RW'(MAX_RETRY);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        retry_d = retry_q;
        hold_d  = '0;
        timer_d = (state_q inside {WAIT_XFER, WAIT_ALIGN}) ? timer_q + 17'd1 : '0;
        case (state_q)
            IDLE: if (start) state_d = (cfg_count != '0) ? CFG : aib_axi_bridge_pkg::RST_HOLD;
            CFG: begin
                if (accept) begin
                    write_d = 1'b0;
                    idx_d   = last ? '0 : idx_q + CW'(1);
                    state_d = !start ? IDLE : last ? aib_axi_bridge_pkg::RST_HOLD : CFG;
                end else if (!write_q) begin
                    state_d = start ? CFG : IDLE;
                    write_d = start;
                    addr_d  = cfg_addr;
                    wdata_d = cfg_wdata;
                end
            end
            aib_axi_bridge_pkg::RST_HOLD: begin
                hold_d = hold_q + HW'(1);
                if (hold_q == HW'(RST_HOLD - 1)) state_d = MAC_RDY;
            end
            MAC_RDY:    state_d = WAIT_XFER;
            WAIT_XFER:  state_d = xfer_ok ? WAIT_ALIGN : tmo ? RETRY : WAIT_XFER;
            WAIT_ALIGN: state_d = (xfer_ok && align_ok) ? ONLINE : tmo ? RETRY : WAIT_ALIGN;
            ONLINE:     if (!(xfer_ok && align_ok)) state_d = RETRY;
            RETRY: begin
                state_d = sat ? FAULT : aib_axi_bridge_pkg::RST_HOLD;
                retry_d = sat ? retry_q : retry_q + RW'(1);
            end
            FAULT:      state_d = FAULT;
            default:    state_d = IDLE;
        endcase
        // a pending AVMM write must complete before the sequencer may drop to IDLE
        if (!start && state_q != CFG) state_d = IDLE;
        if (state_d == IDLE) {idx_d, addr_d, wdata_d, write_d, retry_d} = '0;
        rstn_d   = (state_d inside {MAC_RDY, WAIT_XFER, WAIT_ALIGN, ONLINE}) ? ACT_MASK : '0;
        mac_d    = (state_d inside {WAIT_XFER, WAIT_ALIGN, ONLINE}) ? ACT_MASK : '0;
        online_d = state_d == ONLINE;
        fault_d  = state_d == FAULT;
    end

    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            hold_q   <= '0;
            timer_q  <= '0;
            retry_q  <= '0;
            rstn_q   <= '0;
            mac_q    <= '0;
            online_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            hold_q   <= hold_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            rstn_q   <= rstn_d;
            mac_q    <= mac_d;
            online_q <= online_d;
            fault_q  <= fault_d;
        end
    end

    assign cfg_idx               = idx_q;
    assign avmm.cfg_avmm_addr    = addr_q;
    assign avmm.cfg_avmm_wdata   = wdata_q;
    assign avmm.cfg_avmm_write   = write_q;
    assign avmm.cfg_avmm_read    = 1'b0;
    assign avmm.cfg_avmm_byte_en = AVMM_BYTE_EN_ALL;
    assign ns_adapter_rstn       = rstn_q;
    assign ns_mac_rdy            = mac_q;
    assign link_online           = online_q;
    assign link_fault            = fault_q;
    assign retry_cnt             = retry_q;
    assign state                 = state_q;

endmodule

// File: tb/tb_aib_follower_link_seq.sv
// tb_aib_follower_link_seq: directed bench for the AIB link bring-up sequencer
module tb_aib_follower_link_seq;
    import aib_axi_bridge_pkg::*;

    localparam int NCH = 24, ACT = 2, DEPTH = 16, HOLD = 8, TMO = 100, MAXR = 3;
    localparam logic [NCH-1:0] MASK = 24'h3;

    logic           clk, rst_n, start;
    logic [4:0]     cfg_count;
    logic [3:0]     cfg_idx, st;
    logic [16:0]    cfg_addr;
    logic [31:0]    cfg_wdata;
    logic [NCH-1:0] rstn, mac, ms, sl, al;
    logic           lo, lf;
    logic [1:0]     rc;
    int             n_vec, n_err, wcnt, wait_n, stab_err, b2b_err, stall_cyc;
    bit             prev_stall, prev_acc;
    logic [16:0]    p_addr;
    logic [31:0]    p_data;
    logic [16:0]    acc_addr[$];
    logic [31:0]    acc_data[$];
    logic [3:0]     acc_idx[$];

    aib_follower_link_seq_if bus();

    aib_follower_link_seq #(
        .NBR_CHNLS(NCH), .ACTIVE_CHNLS(ACT), .CFG_DEPTH(DEPTH),
        .RST_HOLD(HOLD), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)
    ) dut (
        .avmm_clk(clk), .avmm_rst_n(rst_n), .start(start), .cfg_count(cfg_count),
        .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .avmm(bus),
        .ns_adapter_rstn(rstn), .ns_mac_rdy(mac), .ms_tx_transfer_en(ms),
        .sl_tx_transfer_en(sl), .m_rx_align_done(al), .link_online(lo),
        .link_fault(lf), .retry_cnt(rc), .state(st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational config ROM
    assign cfg_addr  = 17'h1000 + {13'd0, cfg_idx};
    assign cfg_wdata = 32'hC0DE_0000 + {28'd0, cfg_idx} * 32'd17;

    // PHY model: stall each write for wait_n cycles
    always @(posedge clk or negedge rst_n)
        if (!rst_n) wcnt <= 0;
        else        wcnt <= bus.cfg_avmm_write ? wcnt + 1 : 0;
    assign bus.cfg_avmm_waitreq = bus.cfg_avmm_write && (wcnt < wait_n);

    always @(negedge clk) begin
        if (prev_stall && !(bus.cfg_avmm_write && bus.cfg_avmm_addr == p_addr && bus.cfg_avmm_wdata == p_data))
            stab_err++;
        if (prev_acc && bus.cfg_avmm_write) b2b_err++;
        if (bus.cfg_avmm_write && bus.cfg_avmm_waitreq) stall_cyc++;
        prev_stall = bus.cfg_avmm_write && bus.cfg_avmm_waitreq;
        prev_acc   = bus.cfg_avmm_write && !bus.cfg_avmm_waitreq;
        if (prev_acc) begin
            acc_addr.push_back(bus.cfg_avmm_addr);
            acc_data.push_back(bus.cfg_avmm_wdata);
            acc_idx.push_back(cfg_idx);
        end
        p_addr = bus.cfg_avmm_addr;
        p_data = bus.cfg_avmm_wdata;
    end

    task automatic clear_mon();
        acc_addr.delete();
        acc_data.delete();
        acc_idx.delete();
        stab_err = 0;
        b2b_err = 0;
        stall_cyc = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (st !== IDLE) begin n_err++; $display("FAIL reset_state got %0d exp %0d", st, IDLE); end
        n_vec++; if (rstn !== '0 || mac !== '0) begin n_err++; $display("FAIL reset_rstn_mac got %h/%h exp 0/0", rstn, mac); end
        n_vec++; if (bus.cfg_avmm_write !== 1'b0 || cfg_idx !== 4'd0) begin n_err++; $display("FAIL reset_avmm got wr=%b idx=%0d exp 0/0", bus.cfg_avmm_write, cfg_idx); end
        n_vec++; if (lo !== 1'b0 || lf !== 1'b0 || rc !== 2'd0) begin n_err++; $display("FAIL reset_status got %b%b%0d exp 000", lo, lf, rc); end
        n_vec++; if (bus.cfg_avmm_byte_en !== 4'hF || bus.cfg_avmm_read !== 1'b0) begin n_err++; $display("FAIL byte_en_read got %h/%b exp F/0", bus.cfg_avmm_byte_en, bus.cfg_avmm_read); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (st !== IDLE) begin n_err++; $display("FAIL idle_no_start got %0d exp %0d", st, IDLE); end
    endtask

    task automatic test_cfg();
        clear_mon();
        cfg_count = 5'd3;
        wait_n = 2;
        start = 1'b1;
        for (int c = 0; c < 200 && st !== RST_HOLD; c++) @(negedge clk);
        n_vec++; if (st !== RST_HOLD) begin n_err++; $display("FAIL cfg_done got state %0d exp %0d", st, RST_HOLD); end
        n_vec++; if (acc_addr.size() != 3) begin n_err++; $display("FAIL cfg_writes got %0d exp 3", acc_addr.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= acc_addr.size()) begin n_err++; $display("FAIL cfg_entry%0d missing", i); end
            else if (acc_addr[i] !== 17'h1000 + 17'(i) || acc_data[i] !== 32'hC0DE_0000 + 32'(i) * 32'd17 || acc_idx[i] !== 4'(i)) begin
                n_err++;
                $display("FAIL cfg_entry%0d got %h/%h/%0d exp %h/%h/%0d", i, acc_addr[i], acc_data[i], acc_idx[i],
                         17'h1000 + 17'(i), 32'hC0DE_0000 + 32'(i) * 32'd17, i);
            end
        end
        n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL cfg_stable got %0d violations exp 0", stab_err); end
        n_vec++; if (b2b_err != 0) begin n_err++; $display("FAIL cfg_no_b2b got %0d violations exp 0", b2b_err); end
        n_vec++; if (stall_cyc != 6) begin n_err++; $display("FAIL cfg_stalls got %0d exp 6", stall_cyc); end
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (st !== IDLE) begin n_err++; $display("FAIL cfg_takedown got %0d exp %0d", st, IDLE); end
    endtask

    task automatic test_bringup();
        int n, t_mac, hold_cyc;
        bit mac_seen;
        n = 0; t_mac = 0; hold_cyc = 0; mac_seen = 0;
        cfg_count = 5'd0;
        wait_n = 0;
        start = 1'b1;
        while (n < 200 && lo !== 1'b1) begin
            @(negedge clk);
            n++;
            if (st === RST_HOLD) hold_cyc++;
            if (!mac_seen && mac === MASK) begin mac_seen = 1; t_mac = n; end
            if (mac_seen && n == t_mac + 10) begin ms = MASK; sl = MASK; end
            if (mac_seen && n == t_mac + 20) al = MASK;
        end
        n_vec++; if (lo !== 1'b1 || n != HOLD + 25) begin n_err++; $display("FAIL bringup_latency got online=%b at %0d exp 1 at %0d", lo, n, HOLD + 25); end
        n_vec++; if (t_mac != HOLD + 2) begin n_err++; $display("FAIL mac_rdy_time got %0d exp %0d", t_mac, HOLD + 2); end
        n_vec++; if (hold_cyc != HOLD) begin n_err++; $display("FAIL rst_hold_len got %0d exp %0d", hold_cyc, HOLD); end
        n_vec++; if (rstn !== MASK || mac !== MASK || st !== ONLINE) begin n_err++; $display("FAIL online_outputs got %h/%h/%0d exp %h/%h/%0d", rstn, mac, st, MASK, MASK, ONLINE); end
    endtask

    task automatic test_link_drop();
        int k, hold_cyc, rstn_bad;
        k = 0; hold_cyc = 0; rstn_bad = 0;
        ms = 24'h2;
        while (k < 6 && lo !== 1'b0) begin @(negedge clk); k++; end
        n_vec++; if (lo !== 1'b0) begin n_err++; $display("FAIL drop_online got %b exp 0", lo); end
        n_vec++; if (k > 3) begin n_err++; $display("FAIL drop_latency got %0d exp <=3", k); end
        ms = MASK;
        k = 0;
        while (k < 100 && lo !== 1'b1) begin
            @(negedge clk);
            k++;
            if (st === RST_HOLD) begin hold_cyc++; if (rstn !== '0) rstn_bad++; end
        end
        n_vec++; if (hold_cyc != HOLD || rstn_bad != 0) begin n_err++; $display("FAIL retrain_hold got %0d cyc %0d bad exp %0d/0", hold_cyc, rstn_bad, HOLD); end
        n_vec++; if (lo !== 1'b1 || rc !== 2'd1) begin n_err++; $display("FAIL relink got online=%b retry=%0d exp 1/1", lo, rc); end
    endtask

    task automatic test_timeout_fault();
        int k, wait_cyc, entries;
        logic [3:0] prev;
        k = 0; wait_cyc = 0; entries = 0;
        start = 1'b0;
        al = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (st !== IDLE || rc !== 2'd0) begin n_err++; $display("FAIL stop_clears got %0d/%0d exp %0d/0", st, rc, IDLE); end
        prev = st;
        start = 1'b1;
        while (k < 1000 && lf !== 1'b1) begin
            @(negedge clk);
            k++;
            if (st === WAIT_XFER || st === WAIT_ALIGN) wait_cyc++;
            if (st === RST_HOLD && prev !== RST_HOLD) entries++;
            prev = st;
        end
        n_vec++; if (lf !== 1'b1 || rc !== 2'd3 || st !== FAULT) begin n_err++; $display("FAIL fault got lf=%b retry=%0d st=%0d exp 1/3/%0d", lf, rc, st, FAULT); end
        n_vec++; if (wait_cyc != 4 * TMO) begin n_err++; $display("FAIL timeout_len got %0d exp %0d", wait_cyc, 4 * TMO); end
        n_vec++; if (entries != 4) begin n_err++; $display("FAIL attempts got %0d exp 4", entries); end
        n_vec++; if (rstn !== '0 || mac !== '0 || lo !== 1'b0) begin n_err++; $display("FAIL fault_outputs got %h/%h/%b exp 0/0/0", rstn, mac, lo); end
        repeat (5) @(negedge clk);
        n_vec++; if (st !== FAULT) begin n_err++; $display("FAIL fault_sticky got %0d exp %0d", st, FAULT); end
        start = 1'b0;
        @(negedge clk);
        n_vec++; if (st !== IDLE || lf !== 1'b0 || rc !== 2'd0) begin n_err++; $display("FAIL fault_exit got %0d/%b/%0d exp %0d/0/0", st, lf, rc, IDLE); end
    endtask

    task automatic test_stop_mid_cfg();
        int k;
        k = 0;
        clear_mon();
        cfg_count = 5'd3;
        wait_n = 8;
        start = 1'b1;
        while (k < 10 && bus.cfg_avmm_write !== 1'b1) begin @(negedge clk); k++; end
        n_vec++; if (bus.cfg_avmm_write !== 1'b1) begin n_err++; $display("FAIL stop_write_start got %b exp 1", bus.cfg_avmm_write); end
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++; if (st !== CFG || bus.cfg_avmm_write !== 1'b1 || bus.cfg_avmm_addr !== 17'h1000) begin n_err++; $display("FAIL stop_hold got %0d/%b/%h exp %0d/1/01000", st, bus.cfg_avmm_write, bus.cfg_avmm_addr, CFG); end
        k = 0;
        while (k < 10 && st !== IDLE) begin @(negedge clk); k++; end
        n_vec++; if (st !== IDLE || bus.cfg_avmm_write !== 1'b0 || cfg_idx !== 4'd0 || bus.cfg_avmm_addr !== '0) begin n_err++; $display("FAIL stop_idle got %0d/%b/%0d/%h exp %0d/0/0/0", st, bus.cfg_avmm_write, cfg_idx, bus.cfg_avmm_addr, IDLE); end
        n_vec++; if (acc_addr.size() != 1 || stab_err != 0 || stall_cyc != 8) begin n_err++; $display("FAIL stop_accept got %0d acc %0d err %0d stall exp 1/0/8", acc_addr.size(), stab_err, stall_cyc); end
        n_vec++; if (rstn !== '0 || mac !== '0 || lo !== 1'b0) begin n_err++; $display("FAIL stop_outputs got %h/%h/%b exp 0/0/0", rstn, mac, lo); end
        wait_n = 0;
    endtask

    task automatic test_async_reset();
        int k;
        k = 0;
        cfg_count = 5'd0;
        ms = MASK; sl = MASK; al = MASK;
        start = 1'b1;
        while (k < 100 && lo !== 1'b1) begin @(negedge clk); k++; end
        n_vec++; if (lo !== 1'b1) begin n_err++; $display("FAIL pre_reset_online got %b exp 1", lo); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (st !== IDLE || lo !== 1'b0 || rstn !== '0 || mac !== '0 || rc !== 2'd0) begin n_err++; $display("FAIL async_clear got %0d/%b/%h/%h/%0d exp %0d/0/0/0/0", st, lo, rstn, mac, rc, IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (k < 100 && lo !== 1'b1) begin @(negedge clk); k++; end
        n_vec++; if (lo !== 1'b1 || st !== ONLINE) begin n_err++; $display("FAIL restart got %b/%0d exp 1/%0d", lo, st, ONLINE); end
        start = 1'b0;
        @(negedge clk);
        n_vec++; if (st !== IDLE || lo !== 1'b0) begin n_err++; $display("FAIL final_stop got %0d/%b exp %0d/0", st, lo, IDLE); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; cfg_count = '0;
        ms = '0; sl = '0; al = '0; wait_n = 0;
        clear_mon();
        test_reset();
        test_cfg();
        test_bringup();
        test_link_drop();
        test_timeout_fault();
        test_stop_mid_cfg();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
